pe_mc_receiver: RTL and testbench
=================================

# pe_mc_receiver

Per-PE multicast receiver for the global-buffer bus. It sits directly downstream of the global-buffer bus driver and upstream of a processing element. Each cycle it filters bus beats by comparing the bus TAG with this PE's ID. It buffers each matching {ifmap, filter, psum} beat in a small show-ahead FIFO, frames beats into rows of `kernel_size`, and hands them to the PE under a valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 16, width of ifmap and filter words; psum is 2*DATA_WIDTH
- NUM_COL, 4, number of PE columns; ID/TAG width is $clog2(NUM_COL)
- FIFO_DEPTH, 8, beat buffer entries; power of two, ≥2

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- ifmap_data_i  in  DATA_WIDTH  bus ifmap word
- fltr_data_i  in  DATA_WIDTH  bus filter word
- psum_data_i  in  2*DATA_WIDTH  bus partial sum
- id_i  in  $clog2(NUM_COL)  this PE's ID, static during operation
- tag_i  in  $clog2(NUM_COL)  destination tag of current beat
- ready_i  in  1  bus beat present
- en_i  in  1  caster enable
- kernel_size_i  in  8  beats per row
- bus_ready_o  out  1  receiver can accept (!full && kernel_size_i != 0)
- ifmap_o  out  DATA_WIDTH  FIFO head ifmap
- fltr_o  out  DATA_WIDTH  FIFO head filter
- psum_o  out  2*DATA_WIDTH  FIFO head psum
- valid_o  out  1  FIFO non-empty
- pe_ready_i  in  1  PE consumes head when valid_o
- row_last_o  out  1  head beat is last beat of its row
- row_done_o  out  1  one-cycle pulse: last beat of a row accepted
- row_cnt_o  out  16  completed rows, wraps at 2^16
- overflow_o  out  1  sticky: a matching beat was dropped

## Operation
- Match: `hit = en_i && ready_i && (tag_i == id_i)`.
- Accept: `acc = hit && bus_ready_o`.
- Drop: `hit && !bus_ready_o` drops the beat and sets overflow_o. overflow_o clears only on reset.
- Push: on `acc`, push {ifmap, fltr, psum, last} into the FIFO. `last` = (beat_cnt == row_len-1).
- Pop: on `valid_o && pe_ready_i`.
- FSM IDLE/RECV:
  - IDLE, acc with kernel_size_i==1: stay IDLE, pulse row_done_o, row_cnt_o += 1.
  - IDLE, acc with kernel_size_i>1: latch row_len = kernel_size_i, beat_cnt = 1, go to RECV.
  - RECV, acc: beat_cnt += 1.
  - RECV, acc with beat_cnt == row_len-1: pulse row_done_o, increment row_cnt_o, clear beat_cnt, go to IDLE.
- kernel_size_i changes during RECV are ignored; the latched row_len governs the row.
- en_i or ready_i low during RECV pauses the row. State and beat_cnt are held.
- kernel_size_i == 0 in IDLE: bus_ready_o low, no accepts, matching beats count as drops. In RECV, bus_ready_o uses only !full.
- Push and pop in the same cycle when neither full nor empty: occupancy unchanged, FIFO order preserved.
- bus_ready_o is derived from registered occupancy. When full, a push is refused even if a pop occurs in the same cycle.
- Push into an empty FIFO with pop asserted: valid_o was low, so no pop occurs.

## Timing
- Reset values:
  - bus_ready_o = 0 while rstn low, then (kernel_size_i != 0) after release
  - valid_o = 0, row_last_o = 0, row_done_o = 0, overflow_o = 0, row_cnt_o = 0
  - ifmap_o, fltr_o, psum_o = 0
  - FSM = IDLE, beat_cnt = 0
- Latency: a beat accepted at edge N appears at the FIFO head with valid_o high after edge N, i.e. visible in cycle N+1.
- row_done_o is registered and high for the cycle after the accepting edge.
- row_cnt_o updates in the same cycle that row_done_o asserts.
- Throughput: one beat per cycle in and one out, sustained.
- Reset mid-row: asynchronous clear of FIFO, FSM, counters and flags. The partial row is discarded with no row_done_o.

## Test plan
- **Basic row:** id_i=2, kernel_size_i=3, tag_i=2, en_i=ready_i=1, three beats ifmap 0x0011/0x0022/0x0033, pe_ready_i=1 -> three outputs in order, row_last_o only on 0x0033, one row_done_o pulse, row_cnt_o=1.
- **Tag filtering:** alternate tag_i 1/2 with id_i=2, kernel_size_i=2, four beats -> only the two tag-2 beats are output, row_cnt_o=1, overflow_o=0.
- **Backpressure:** pe_ready_i=0, FIFO_DEPTH=8, 10 matching beats with kernel_size_i=5 -> bus_ready_o low after 8 accepts, 2 drops, overflow_o=1, row_cnt_o=1. Then pe_ready_i=1 -> 8 beats drain, valid_o low.
- **Mid-row kernel change and pause:** kernel_size_i=4 at first beat, changed to 2 after beat 1, en_i low for 3 cycles after beat 2 -> row completes on the 4th accepted beat, exactly one row_done_o pulse.
- **Zero kernel:** kernel_size_i=0 in IDLE with a matching beat -> bus_ready_o=0, no push, overflow_o=1.
- **Reset mid-row:** rstn pulsed low after 2 of 4 beats with 2 beats buffered -> all outputs return to reset values. A following 4-beat row yields row_cnt_o=1 with only the new data.

Source files
------------

// File: rtl/pe_mc_receiver.sv
// Multicast receiver for one PE: filters global-buffer bus beats by tag, buffers them in a
// show-ahead FIFO, frames them into rows of kernel_size and hands them to the PE.
module pe_mc_receiver #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int FIFO_DEPTH = 8,
    localparam int IDW       = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [DATA_WIDTH-1:0]   ifmap_data_i,
    input  logic [DATA_WIDTH-1:0]   fltr_data_i,
    input  logic [2*DATA_WIDTH-1:0] psum_data_i,
    input  logic [IDW-1:0]          id_i,
    input  logic [IDW-1:0]          tag_i,
    input  logic                    ready_i,
    input  logic                    en_i,
    input  logic [7:0]              kernel_size_i,
    output logic                    bus_ready_o,
    output logic [DATA_WIDTH-1:0]   ifmap_o,
    output logic [DATA_WIDTH-1:0]   fltr_o,
    output logic [2*DATA_WIDTH-1:0] psum_o,
    output logic                    valid_o,
    input  logic                    pe_ready_i,
    output logic                    row_last_o,
    output logic                    row_done_o,
    output logic [15:0]             row_cnt_o,
    output logic                    overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 4 * DATA_WIDTH + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [7:0]     r_beat_cnt;
    logic [7:0]     w_beat_cnt_next;
    logic [7:0]     r_row_len;
    logic [7:0]     w_row_len_next;
    logic           r_row_done;
    logic           w_row_done_next;
    logic [15:0]    r_row_cnt;
    logic [15:0]    w_row_cnt_next;
    logic           r_overflow;

    logic [EW-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    logic           w_full;
    logic           w_empty;
    logic           w_hit;
    logic           w_acc;
    logic           w_pop;
    logic           w_last;
    logic           w_bus_ready;
    logic [EW-1:0]  w_head;

    assign w_full  = (r_count == FIFO_DEPTH[AW:0]);
    assign w_empty = (r_count == '0);

    // Once a row is open its latched length governs it, so a zero kernel only blocks new rows.
    assign w_bus_ready = rstn && !w_full && ((r_state == S_RECV) || (kernel_size_i != 8'd0));
    assign w_hit       = en_i && ready_i && (tag_i == id_i);
    assign w_acc       = w_hit && w_bus_ready;
    assign w_pop       = !w_empty && pe_ready_i;
    assign w_last      = (r_state == S_RECV) ? (r_beat_cnt == r_row_len - 8'd1)
                                             : (kernel_size_i == 8'd1);

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_mem[r_wr_ptr] <= {ifmap_data_i, fltr_data_i, psum_data_i, w_last};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_acc && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_acc && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_row_len  <= '0;
            r_row_done <= 1'b0;
            r_row_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_beat_cnt <= w_beat_cnt_next;
            r_row_len  <= w_row_len_next;
            r_row_done <= w_row_done_next;
            r_row_cnt  <= w_row_cnt_next;
            if (w_hit && !w_bus_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_beat_cnt_next = r_beat_cnt;
        w_row_len_next  = r_row_len;
        w_row_done_next = 1'b0;
        w_row_cnt_next  = r_row_cnt;
        if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    if (kernel_size_i == 8'd1) begin
                        w_row_done_next = 1'b1;
                        w_row_cnt_next  = r_row_cnt + 16'd1;
                    end else begin
                        w_row_len_next  = kernel_size_i;
                        w_beat_cnt_next = 8'd1;
                        w_state_next    = S_RECV;
                    end
                end
                S_RECV: begin
                    if (w_last) begin
                        w_row_done_next = 1'b1;
                        w_row_cnt_next  = r_row_cnt + 16'd1;
                        w_beat_cnt_next = '0;
                        w_state_next    = S_IDLE;
                    end else begin
                        w_beat_cnt_next = r_beat_cnt + 8'd1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Head fields are forced to zero while empty so stale memory never leaks out.
    assign w_head     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign ifmap_o    = w_head[EW-1 -: DATA_WIDTH];
    assign fltr_o     = w_head[EW-1-DATA_WIDTH -: DATA_WIDTH];
    assign psum_o     = w_head[2*DATA_WIDTH:1];
    assign row_last_o = w_head[0];
    assign valid_o    = !w_empty;

    assign bus_ready_o = w_bus_ready;
    assign row_done_o  = r_row_done;
    assign row_cnt_o   = r_row_cnt;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_pe_mc_receiver.sv
// Bench for pe_mc_receiver: directed scenarios plus randomized traffic, every cycle checked
// against a queue-based model of the receiver's row/FIFO behaviour.
module tb_pe_mc_receiver;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] ifmap_data_i, fltr_data_i;
    logic [2*DW-1:0] psum_data_i;
    logic [1:0]    id_i, tag_i;
    logic          ready_i, en_i, pe_ready_i;
    logic [7:0]    kernel_size_i;
    logic          bus_ready_o, valid_o, row_last_o, row_done_o, overflow_o;
    logic [DW-1:0] ifmap_o, fltr_o;
    logic [2*DW-1:0] psum_o;
    logic [15:0]   row_cnt_o;

    always #5 clk = ~clk;

    pe_mc_receiver #(.DATA_WIDTH(DW), .NUM_COL(NC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rstn(rstn),
        .ifmap_data_i(ifmap_data_i), .fltr_data_i(fltr_data_i), .psum_data_i(psum_data_i),
        .id_i(id_i), .tag_i(tag_i), .ready_i(ready_i), .en_i(en_i),
        .kernel_size_i(kernel_size_i), .bus_ready_o(bus_ready_o),
        .ifmap_o(ifmap_o), .fltr_o(fltr_o), .psum_o(psum_o), .valid_o(valid_o),
        .pe_ready_i(pe_ready_i), .row_last_o(row_last_o), .row_done_o(row_done_o),
        .row_cnt_o(row_cnt_o), .overflow_o(overflow_o)
    );

    typedef struct packed {
        logic [15:0] ifm;
        logic [15:0] flt;
        logic [31:0] ps;
        logic        last;
    } beat_t;

    // Model: queue of buffered beats plus the progress of the currently open row.
    beat_t       mq[$];
    logic        m_in_row;
    int          m_row_len, m_beats;
    logic        m_ovf, m_done;
    logic [15:0] m_row_cnt;

    int          n_cmp = 0, n_bad = 0, n_done = 0;
    logic [16:0] obs[$];
    logic        s_bus_ready, s_valid, s_ovf;
    logic [15:0] s_row_cnt;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        mq.delete();
        m_in_row = 1'b0; m_row_len = 0; m_beats = 0;
        m_ovf = 1'b0; m_done = 1'b0; m_row_cnt = '0;
        n_done = 0;
        obs.delete();
    endtask

    task automatic step(input logic en, input logic rdy, input logic [1:0] tag,
                        input logic [7:0] ks, input logic per, input logic [15:0] ifm);
        logic  exp_ready, hit, acc, pop;
        beat_t b;
        int    len;
        @(negedge clk);
        en_i = en; ready_i = rdy; tag_i = tag; kernel_size_i = ks; pe_ready_i = per;
        ifmap_data_i = ifm; fltr_data_i = 16'($urandom); psum_data_i = $urandom;
        #1;
        exp_ready = (mq.size() < FD) && (m_in_row || ks != 8'd0);
        chk("bus_ready", 64'(bus_ready_o), 64'(exp_ready));
        chk("valid", 64'(valid_o), 64'(mq.size() > 0));
        chk("row_done", 64'(row_done_o), 64'(m_done));
        chk("row_cnt", 64'(row_cnt_o), 64'(m_row_cnt));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        if (mq.size() > 0) begin
            chk("ifmap", 64'(ifmap_o), 64'(mq[0].ifm));
            chk("fltr", 64'(fltr_o), 64'(mq[0].flt));
            chk("psum", 64'(psum_o), 64'(mq[0].ps));
            chk("row_last", 64'(row_last_o), 64'(mq[0].last));
        end else begin
            chk("row_last_empty", 64'(row_last_o), 64'd0);
        end
        s_bus_ready = bus_ready_o; s_valid = valid_o; s_ovf = overflow_o; s_row_cnt = row_cnt_o;
        if (row_done_o) n_done++;
        if (valid_o && per) obs.push_back({row_last_o, ifmap_o});

        hit = en && rdy && (tag == id_i);
        acc = hit && exp_ready;
        pop = (mq.size() > 0) && per;
        @(posedge clk);
        if (hit && !exp_ready) m_ovf = 1'b1;
        m_done = 1'b0;
        if (pop) void'(mq.pop_front());
        if (acc) begin
            len    = m_in_row ? m_row_len : int'(ks);
            b.ifm  = ifm;
            b.flt  = fltr_data_i;
            b.ps   = psum_data_i;
            b.last = (m_beats + 1 == len);
            mq.push_back(b);
            if (b.last) begin
                m_done = 1'b1;
                m_row_cnt++;
                m_in_row = 1'b0;
                m_beats = 0;
            end else begin
                m_in_row = 1'b1;
                m_row_len = len;
                m_beats++;
            end
        end
    endtask

    task automatic idle(input int n, input logic per);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 8'd3, per, 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en_i = 1'b0; ready_i = 1'b0; pe_ready_i = 1'b0; kernel_size_i = 8'd3;
        rstn = 1'b0;
        #1;
        chk("rst_bus_ready", 64'(bus_ready_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_row_last", 64'(row_last_o), 64'd0);
        chk("rst_row_done", 64'(row_done_o), 64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        chk("rst_row_cnt", 64'(row_cnt_o), 64'd0);
        chk("rst_ifmap", 64'(ifmap_o), 64'd0);
        chk("rst_fltr", 64'(fltr_o), 64'd0);
        chk("rst_psum", 64'(psum_o), 64'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [7:0] ks_tab [6];
        logic [7:0] ks;
        int         per_pct;
        ks_tab = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8};
        rstn = 1'b0; id_i = 2'd2; tag_i = '0; en_i = 1'b0; ready_i = 1'b0; pe_ready_i = 1'b0;
        kernel_size_i = 8'd3; ifmap_data_i = '0; fltr_data_i = '0; psum_data_i = '0;
        do_reset();

        // Basic row of three beats.
        step(1, 1, 2'd2, 8'd3, 1, 16'h0011);
        step(1, 1, 2'd2, 8'd3, 1, 16'h0022);
        step(1, 1, 2'd2, 8'd3, 1, 16'h0033);
        idle(4, 1'b1);
        chk("basic_cnt", 64'(s_row_cnt), 64'd1);
        chk("basic_pulses", 64'(n_done), 64'd1);
        chk("basic_nout", 64'(obs.size()), 64'd3);
        if (obs.size() == 3) begin
            chk("basic_out0", 64'(obs[0]), 64'h0_0011);
            chk("basic_out1", 64'(obs[1]), 64'h0_0022);
            chk("basic_out2", 64'(obs[2]), 64'h1_0033);
        end

        // Tag filtering.
        do_reset();
        step(1, 1, 2'd1, 8'd2, 1, 16'h00A1);
        step(1, 1, 2'd2, 8'd2, 1, 16'h00A2);
        step(1, 1, 2'd1, 8'd2, 1, 16'h00A3);
        step(1, 1, 2'd2, 8'd2, 1, 16'h00A4);
        idle(4, 1'b1);
        chk("tag_cnt", 64'(s_row_cnt), 64'd1);
        chk("tag_ovf", 64'(s_ovf), 64'd0);
        chk("tag_nout", 64'(obs.size()), 64'd2);
        if (obs.size() == 2) begin
            chk("tag_out0", 64'(obs[0]), 64'h0_00A2);
            chk("tag_out1", 64'(obs[1]), 64'h1_00A4);
        end

        // Backpressure: 10 beats into an 8-deep FIFO with the PE stalled.
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1, 2'd2, 8'd5, 0, 16'(16'h0100 + i));
        step(0, 0, 2'd0, 8'd5, 0, 16'd0);
        chk("bp_ovf", 64'(s_ovf), 64'd1);
        chk("bp_cnt", 64'(s_row_cnt), 64'd1);
        chk("bp_full", 64'(s_bus_ready), 64'd0);
        idle(10, 1'b1);
        chk("bp_drained", 64'(obs.size()), 64'd8);
        chk("bp_valid", 64'(s_valid), 64'd0);

        // Kernel change mid-row is ignored; enable gap pauses the row.
        do_reset();
        step(1, 1, 2'd2, 8'd4, 1, 16'h0C01);
        step(1, 1, 2'd2, 8'd2, 1, 16'h0C02);
        for (int i = 0; i < 3; i++) step(0, 1, 2'd2, 8'd2, 1, 16'h0EEE);
        step(1, 1, 2'd2, 8'd2, 1, 16'h0C03);
        step(1, 1, 2'd2, 8'd2, 1, 16'h0C04);
        chk("kc_cnt_before", 64'(s_row_cnt), 64'd0);
        idle(3, 1'b1);
        chk("kc_cnt", 64'(s_row_cnt), 64'd1);
        chk("kc_pulses", 64'(n_done), 64'd1);

        // Zero kernel in IDLE drops the beat.
        do_reset();
        step(1, 1, 2'd2, 8'd0, 1, 16'h0D00);
        chk("zk_bus_ready", 64'(s_bus_ready), 64'd0);
        step(0, 0, 2'd0, 8'd0, 1, 16'd0);
        chk("zk_ovf", 64'(s_ovf), 64'd1);
        chk("zk_valid", 64'(s_valid), 64'd0);

        // Reset in the middle of a row with beats buffered.
        do_reset();
        step(1, 1, 2'd2, 8'd4, 0, 16'h0F01);
        step(1, 1, 2'd2, 8'd4, 0, 16'h0F02);
        step(0, 0, 2'd0, 8'd4, 0, 16'd0);
        chk("mr_valid_pre", 64'(s_valid), 64'd1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 2'd2, 8'd4, 1, 16'(16'h00B1 + i));
        idle(4, 1'b1);
        chk("mr_cnt", 64'(s_row_cnt), 64'd1);
        chk("mr_nout", 64'(obs.size()), 64'd4);
        if (obs.size() == 4) begin
            chk("mr_out0", 64'(obs[0]), 64'h0_00B1);
            chk("mr_out3", 64'(obs[3]), 64'h1_00B4);
        end

        // Randomized traffic with varying PE readiness.
        do_reset();
        ks = 8'd3;
        per_pct = 80;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) per_pct = int'($urandom_range(10, 100));
            if ($urandom_range(0, 7) == 0) ks = ks_tab[$urandom_range(0, 5)];
            if (c == 2000) do_reset();
            step($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0,
                 2'($urandom_range(0, 3)), ks,
                 int'($urandom_range(1, 100)) <= per_pct, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
